fport_out_depacketizer: RTL and testbench
=========================================

# fport_out_depacketizer

Read-side consumer of the fabric-port-out flit FIFO. Pops flits of one packet from the FIFO, strips control bits, packs payloads into a single wide word and presents it to the attached module over a valid/ready handshake. Uses the FIFO's `next_is_tail` look-ahead to stop reading exactly at the packet boundary, without a bubble between flits.

## Interface
- `WIDTH`, 36: flit width. Layout: [WIDTH-1] valid, [WIDTH-2] head, [WIDTH-3] tail, [WIDTH-4:0] payload (P = WIDTH-3 bits).
- `MAX_FLITS`, 4: maximum flits per packet (≥2).
- `clk`  in  1  single clock. One clock; all logic synchronous to `clk`.
- `clear`  in  1  reset, synchronous, active-high.
- `fifo_data`  in  WIDTH  FIFO read data; valid the cycle after a `fifo_read_en` cycle.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_next_is_tail`  in  1  tail bit of the flit the next read returns; meaningful only when `fifo_empty`=0.
- `fifo_read_en`  out  1  pop request; never asserted while `fifo_empty`=1 or during `clear`.
- `o_data`  out  MAX_FLITS*P  packed payload; flit i at [i*P +: P], unused slots zero.
- `o_num_flits`  out  clog2(MAX_FLITS+1)  flits in current packet (1..MAX_FLITS).
- `o_valid`  out  1  packet available.
- `i_ready`  in  1  consumer accepts packet when `o_valid`&`i_ready`.
- `o_error`  out  2  sticky: [0] first flit lacks head or any flit lacks valid; [1] packet cut at MAX_FLITS without tail.

## Operation
- States: COLLECT, LAST, OUT. Reset state COLLECT.
- COLLECT: `fifo_read_en` = ~`fifo_empty`. Counter `rd_cnt` increments per read. If a read is issued with `fifo_next_is_tail`=1, or `rd_cnt`=MAX_FLITS-1 at that read, go to LAST.
- LAST: `fifo_read_en`=0; final flit captured this cycle; go to OUT.
- OUT: `o_valid`=1, `o_data`/`o_num_flits` stable. On `i_ready`: go to COLLECT, zero `o_data` slots, `rd_cnt`, `wr_cnt`. No FIFO reads in OUT.
- Capture: flag `rd_pend` = registered `fifo_read_en`. When `rd_pend`=1, payload `fifo_data[WIDTH-4:0]` written to slot `wr_cnt`, `wr_cnt`++. `o_num_flits` = `wr_cnt`.
- Checks on each captured flit: slot 0 with head=0, or any flit with valid=0 → set `o_error[0]`. Forced end (MAX_FLITS reached, captured tail=0) → set `o_error[1]`. Packet is still delivered.
- Stalls in COLLECT (FIFO empty mid-packet): hold state and captured slots, resume when non-empty.
- Errors clear only on `clear`.

## Timing
- Reset (`clear`=1 at an edge): state COLLECT, `o_valid`=0, `o_data`=0, `o_num_flits`=0, `o_error`=0, `fifo_read_en`=0 (combinationally forced low while `clear`=1), `rd_pend`=0.
- Clear mid-packet: partial packet discarded; the FIFO is cleared by the same `clear`.
- k-flit packet, FIFO continuously non-empty, first read cycle c: reads c..c+k-1, captures end of c+1..c+k, LAST at c+k, `o_valid`=1 from c+k+1.
- Throughput: k+2 cycles per packet when `i_ready` held high (accept cycle in OUT, next read cycle after).
- `o_valid` held until accepted; outputs do not change while `o_valid`=1 and `i_ready`=0.
- Single-flit packet (head+tail): one read, LAST next cycle, `o_valid` two cycles after the read.

## Test plan
- 3-flit packet (payloads 0xA,0xB,0xC, tail on third), `i_ready`=1 → `fifo_read_en` 3 consecutive cycles, `o_valid` 4 cycles after the first read, `o_data` = {0,C,B,A} slots, `o_num_flits`=3, `o_error`=0.
- Single-flit packet then immediate 2-flit packet → two accepted packets, `o_num_flits` 1 then 2, no read issued during OUT.
- 4-flit packet with FIFO empty for 3 cycles after flit 2 → `fifo_read_en` low during the gap, final `o_data` correct, no lost or duplicated flit.
- `i_ready`=0 for 5 cycles with packet pending and more flits in FIFO → `o_valid` and `o_data` stable, `fifo_read_en`=0 until acceptance.
- 5 flits without tail, MAX_FLITS=4 → packet of 4 delivered, `o_error[1]`=1; 5th flit starts next packet with head=0 → `o_error[0]`=1.
- `clear` asserted after 2 of 4 flits captured → next cycle all outputs 0, state COLLECT, following packet delivered cleanly.

Source files
------------

// File: rtl/fport_out_depacketizer.sv
// Drains one packet at a time from the fabric-port-out flit FIFO, packs the
// payloads into a wide word and hands it over with a valid/ready handshake.
module fport_out_depacketizer #(
    parameter int WIDTH     = 36,
    parameter int MAX_FLITS = 4,
    localparam int P        = WIDTH - 3,
    localparam int CW       = $clog2(MAX_FLITS + 1)
) (
    input  logic                   clk,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       fifo_data,
    input  logic                   fifo_empty,
    input  logic                   fifo_next_is_tail,
    output logic                   fifo_read_en,
    output logic [MAX_FLITS*P-1:0] o_data,
    output logic [CW-1:0]          o_num_flits,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [1:0]             o_error
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        LAST    = 2'd1,
        OUT     = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          rd_cnt_q, rd_cnt_d;
    logic [CW-1:0]          wr_cnt_q, wr_cnt_d;
    logic                   rd_pend_q, rd_pend_d;
    logic [MAX_FLITS*P-1:0] data_q, data_d;
    logic [1:0]             error_q, error_d;
    logic                   valid_q, valid_d;
    logic                   read_en;

    // The look-ahead tail bit lets reads stop exactly at the packet boundary.
    assign read_en      = (state_q == COLLECT) && !fifo_empty && !clear;
    assign fifo_read_en = read_en;

    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        data_d    = data_q;
        error_d   = error_q;
        valid_d   = valid_q;
        rd_pend_d = read_en;

        // Read data arrives one cycle after the pop request.
        if (rd_pend_q) begin
            for (int i = 0; i < MAX_FLITS; i++) begin
                if (wr_cnt_q == CW'(i)) begin
                    data_d[i*P +: P] = fifo_data[P-1:0];
                end
            end
            wr_cnt_d = wr_cnt_q + CW'(1);
            if (!fifo_data[WIDTH-1] || ((wr_cnt_q == '0) && !fifo_data[WIDTH-2])) begin
                error_d[0] = 1'b1;
            end
            if ((wr_cnt_q == CW'(MAX_FLITS - 1)) && !fifo_data[WIDTH-3]) begin
                error_d[1] = 1'b1;
            end
        end

        unique case (state_q)
            COLLECT: begin
                if (read_en) begin
                    rd_cnt_d = rd_cnt_q + CW'(1);
                    if (fifo_next_is_tail || (rd_cnt_q == CW'(MAX_FLITS - 1))) begin
                        state_d = LAST;
                    end
                end
            end
            LAST: begin
                state_d = OUT;
                valid_d = 1'b1;
            end
            OUT: begin
                if (i_ready) begin
                    state_d  = COLLECT;
                    valid_d  = 1'b0;
                    data_d   = '0;
                    rd_cnt_d = '0;
                    wr_cnt_d = '0;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q   <= COLLECT;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            rd_pend_q <= 1'b0;
            data_q    <= '0;
            error_q   <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_pend_q <= rd_pend_d;
            data_q    <= data_d;
            error_q   <= error_d;
            valid_q   <= valid_d;
        end
    end

    assign o_data      = data_q;
    assign o_num_flits = wr_cnt_q;
    assign o_valid     = valid_q;
    assign o_error     = error_q;

endmodule

// File: tb/tb_fport_out_depacketizer.sv
// Bench for fport_out_depacketizer: behavioural flit FIFO, packet-level
// reference model and per-scenario tasks.
module tb_fport_out_depacketizer;

    localparam int WIDTH = 36;
    localparam int MAXF  = 4;
    localparam int P     = WIDTH - 3;
    localparam int CW    = $clog2(MAXF + 1);
    localparam int DW    = MAXF * P;

    logic             clk = 1'b0;
    logic             clear = 1'b1;
    logic [WIDTH-1:0] fifo_data = '0;
    logic             fifo_empty;
    logic             fifo_next_is_tail;
    logic             fifo_read_en;
    logic [DW-1:0]    o_data;
    logic [CW-1:0]    o_num_flits;
    logic             o_valid;
    logic             i_ready = 1'b0;
    logic [1:0]       o_error;

    int total = 0;
    int bad   = 0;

    fport_out_depacketizer #(.WIDTH(WIDTH), .MAX_FLITS(MAXF)) dut (
        .clk               (clk),
        .clear             (clear),
        .fifo_data         (fifo_data),
        .fifo_empty        (fifo_empty),
        .fifo_next_is_tail (fifo_next_is_tail),
        .fifo_read_en      (fifo_read_en),
        .o_data            (o_data),
        .o_num_flits       (o_num_flits),
        .o_valid           (o_valid),
        .i_ready           (i_ready),
        .o_error           (o_error)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO; hold forces it to look empty without losing contents.
    logic [WIDTH-1:0] fmem [64];
    int unsigned      wr_ptr = 0;
    int unsigned      rd_ptr = 0;
    logic             hold = 1'b0;

    assign fifo_empty        = hold || (wr_ptr == rd_ptr);
    assign fifo_next_is_tail = fmem[rd_ptr % 64][WIDTH-3];

    always @(posedge clk) begin
        if (clear) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_read_en) begin
            fifo_data <= fmem[rd_ptr % 64];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    logic [WIDTH-1:0] sent [$];

    function automatic logic [WIDTH-1:0] mk(input logic v, input logic h, input logic t,
                                            input logic [P-1:0] pl);
        return {v, h, t, pl};
    endfunction

    function automatic logic [P-1:0] rnd_pl();
        return P'({$urandom, $urandom});
    endfunction

    task automatic push(input logic [WIDTH-1:0] f);
        fmem[wr_ptr % 64] = f;
        wr_ptr = wr_ptr + 1;
        sent.push_back(f);
    endtask

    // Monitor: records accepted packets and counts protocol violations.
    logic [DW-1:0] got_data [$];
    int            got_nf   [$];
    logic [1:0]    got_err  [$];
    int            viol = 0;
    logic          pv = 1'b0, pr = 1'b0;
    logic [DW-1:0] pd = '0;
    logic [CW-1:0] pn = '0;
    logic [1:0]    pe = '0;

    always begin
        @(negedge clk);
        #3;
        if (fifo_read_en && fifo_empty) viol++;
        if (fifo_read_en && (o_valid || clear)) viol++;
        if (pv && !pr && !clear &&
            (!o_valid || o_data !== pd || o_num_flits !== pn || o_error !== pe)) viol++;
        if (o_valid && i_ready && !clear) begin
            got_data.push_back(o_data);
            got_nf.push_back(int'(o_num_flits));
            got_err.push_back(o_error);
        end
        pv = o_valid; pr = i_ready; pd = o_data; pn = o_num_flits; pe = o_error;
    end

    // Reference model: split the flit stream into packets by tail / size limit.
    logic [DW-1:0] exp_data [64];
    int            exp_nf   [64];
    logic [1:0]    exp_err  [64];
    logic [1:0]    model_err = '0;

    task automatic model_build(output int n);
        logic [DW-1:0] acc = '0;
        int            cnt = 0;
        logic [1:0]    e = model_err;
        n = 0;
        foreach (sent[k]) begin
            logic [WIDTH-1:0] f = sent[k];
            if (!f[WIDTH-1] || (cnt == 0 && !f[WIDTH-2])) e[0] = 1'b1;
            acc[cnt*P +: P] = f[P-1:0];
            cnt++;
            if (f[WIDTH-3] || cnt == MAXF) begin
                if (!f[WIDTH-3]) e[1] = 1'b1;
                exp_data[n] = acc; exp_nf[n] = cnt; exp_err[n] = e;
                n++; acc = '0; cnt = 0;
            end
        end
        model_err = e;
    endtask

    task automatic flush_logs();
        sent.delete(); got_data.delete(); got_nf.delete(); got_err.delete();
    endtask

    task automatic wait_got(input int n, input int budget, output bit ok);
        int c = 0;
        while (got_nf.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk);
        ok = (got_nf.size() >= n);
    endtask

    task automatic test_reset();
        clear = 1'b1;
        repeat (2) @(negedge clk);
        push(mk(1, 1, 1, 33'h5));
        #1;
        total++; if (fifo_read_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b want=0", fifo_read_en); end
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", o_valid); end
        total++; if (o_data !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", o_data); end
        total++; if (o_num_flits !== '0) begin bad++; $display("FAIL reset_nf got=%0d want=0", o_num_flits); end
        total++; if (o_error !== 2'b00) begin bad++; $display("FAIL reset_err got=%b want=00", o_error); end
        @(negedge clk);
        clear = 1'b0;
        model_err = '0;
        flush_logs();
        #1;
        total++; if (fifo_read_en !== 1'b0) begin bad++; $display("FAIL reset_flushed_rd got=%b want=0", fifo_read_en); end
        @(negedge clk);
    endtask

    task automatic test_three_flit();
        int first_rd = -1, first_v = -1;
        logic [31:0] rmask = '0;
        logic [DW-1:0] vd = '0, ed = '0;
        int vn = 0;
        logic [1:0] ve = '0;
        i_ready = 1'b1;
        push(mk(1, 1, 0, 33'hA));
        push(mk(1, 0, 0, 33'hB));
        push(mk(1, 0, 1, 33'hC));
        for (int cyc = 0; cyc < 20; cyc++) begin
            #1;
            if (fifo_read_en) begin
                if (first_rd < 0) first_rd = cyc;
                rmask[cyc] = 1'b1;
            end
            if (o_valid && first_v < 0) begin
                first_v = cyc; vd = o_data; vn = int'(o_num_flits); ve = o_error;
            end
            @(negedge clk);
        end
        ed[0*P +: P] = 33'hA; ed[1*P +: P] = 33'hB; ed[2*P +: P] = 33'hC;
        total++; if (first_rd < 0 || rmask !== (32'h7 << first_rd)) begin bad++; $display("FAIL three_reads got=%h want=7<<%0d", rmask, first_rd); end
        total++; if (first_v - first_rd !== 4) begin bad++; $display("FAIL three_latency got=%0d want=4", first_v - first_rd); end
        total++; if (vd !== ed) begin bad++; $display("FAIL three_data got=%h want=%h", vd, ed); end
        total++; if (vn !== 3) begin bad++; $display("FAIL three_nf got=%0d want=3", vn); end
        total++; if (ve !== 2'b00) begin bad++; $display("FAIL three_err got=%b want=00", ve); end
        flush_logs();
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n;
        i_ready = 1'b1;
        push(mk(1, 1, 1, rnd_pl()));
        push(mk(1, 1, 0, rnd_pl()));
        push(mk(1, 0, 1, rnd_pl()));
        wait_got(2, 40, ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_timeout got=%0d want=2", got_nf.size()); end
        model_build(n);
        for (int k = 0; k < n && k < got_nf.size(); k++) begin
            total++; if (got_data[k] !== exp_data[k] || got_nf[k] !== exp_nf[k] || got_err[k] !== exp_err[k]) begin
                bad++; $display("FAIL b2b_pkt%0d got=%h/%0d/%b want=%h/%0d/%b", k, got_data[k], got_nf[k], got_err[k], exp_data[k], exp_nf[k], exp_err[k]); end
        end
        total++; if (viol !== 0) begin bad++; $display("FAIL b2b_protocol got=%0d want=0", viol); end
        flush_logs();
    endtask

    task automatic test_gap();
        bit ok;
        int n;
        i_ready = 1'b1;
        push(mk(1, 1, 0, rnd_pl()));
        push(mk(1, 0, 0, rnd_pl()));
        repeat (2) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            #1;
            total++; if (fifo_read_en !== 1'b0 || o_valid !== 1'b0) begin bad++; $display("FAIL gap_idle%0d got=%b%b want=00", g, fifo_read_en, o_valid); end
            @(negedge clk);
        end
        #1;
        total++; if (o_num_flits !== CW'(2)) begin bad++; $display("FAIL gap_partial got=%0d want=2", o_num_flits); end
        push(mk(1, 0, 0, rnd_pl()));
        push(mk(1, 0, 1, rnd_pl()));
        wait_got(1, 30, ok);
        total++; if (!ok) begin bad++; $display("FAIL gap_timeout got=%0d want=1", got_nf.size()); end
        model_build(n);
        for (int k = 0; k < n && k < got_nf.size(); k++) begin
            total++; if (got_data[k] !== exp_data[k] || got_nf[k] !== exp_nf[k] || got_err[k] !== exp_err[k]) begin
                bad++; $display("FAIL gap_pkt%0d got=%h/%0d/%b want=%h/%0d/%b", k, got_data[k], got_nf[k], got_err[k], exp_data[k], exp_nf[k], exp_err[k]); end
        end
        flush_logs();
    endtask

    task automatic test_stall();
        bit ok;
        int n, c = 0;
        logic [DW-1:0] snap;
        i_ready = 1'b0;
        push(mk(1, 1, 0, rnd_pl()));
        push(mk(1, 0, 0, rnd_pl()));
        push(mk(1, 0, 1, rnd_pl()));
        push(mk(1, 1, 0, rnd_pl()));
        push(mk(1, 0, 1, rnd_pl()));
        while (!o_valid && c < 20) begin @(negedge clk); c++; end
        #1;
        snap = o_data;
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL stall_valid_timeout got=%b want=1", o_valid); end
        for (int s = 0; s < 5; s++) begin
            @(negedge clk); #1;
            total++; if (o_valid !== 1'b1 || o_data !== snap || fifo_read_en !== 1'b0) begin
                bad++; $display("FAIL stall_hold%0d got=%b/%h/%b want=1/%h/0", s, o_valid, o_data, fifo_read_en, snap); end
        end
        @(negedge clk);
        i_ready = 1'b1;
        wait_got(2, 30, ok);
        total++; if (!ok) begin bad++; $display("FAIL stall_timeout got=%0d want=2", got_nf.size()); end
        model_build(n);
        for (int k = 0; k < n && k < got_nf.size(); k++) begin
            total++; if (got_data[k] !== exp_data[k] || got_nf[k] !== exp_nf[k] || got_err[k] !== exp_err[k]) begin
                bad++; $display("FAIL stall_pkt%0d got=%h/%0d/%b want=%h/%0d/%b", k, got_data[k], got_nf[k], got_err[k], exp_data[k], exp_nf[k], exp_err[k]); end
        end
        flush_logs();
    endtask

    task automatic test_random();
        int n, c = 0;
        for (int p = 0; p < 12; p++) begin
            int len = $urandom_range(1, MAXF);
            for (int f = 0; f < len; f++) push(mk(1, f == 0, f == len - 1, rnd_pl()));
        end
        while (got_nf.size() < 12 && c < 600) begin
            @(negedge clk);
            i_ready = ($urandom_range(0, 3) != 0);
            hold    = ($urandom_range(0, 4) == 0);
            c++;
        end
        hold = 1'b0;
        i_ready = 1'b1;
        total++; if (got_nf.size() !== 12) begin bad++; $display("FAIL rand_count got=%0d want=12", got_nf.size()); end
        model_build(n);
        for (int k = 0; k < n && k < got_nf.size(); k++) begin
            total++; if (got_data[k] !== exp_data[k] || got_nf[k] !== exp_nf[k] || got_err[k] !== exp_err[k]) begin
                bad++; $display("FAIL rand_pkt%0d got=%h/%0d/%b want=%h/%0d/%b", k, got_data[k], got_nf[k], got_err[k], exp_data[k], exp_nf[k], exp_err[k]); end
        end
        total++; if (viol !== 0) begin bad++; $display("FAIL rand_protocol got=%0d want=0", viol); end
        repeat (3) @(negedge clk);
        flush_logs();
    endtask

    task automatic test_cut();
        bit ok;
        int n;
        i_ready = 1'b1;
        for (int f = 0; f < 4; f++) push(mk(1, f == 0, 0, rnd_pl()));
        push(mk(1, 0, 1, rnd_pl()));
        wait_got(2, 40, ok);
        total++; if (!ok) begin bad++; $display("FAIL cut_timeout got=%0d want=2", got_nf.size()); end
        model_build(n);
        for (int k = 0; k < n && k < got_nf.size(); k++) begin
            total++; if (got_data[k] !== exp_data[k] || got_nf[k] !== exp_nf[k] || got_err[k] !== exp_err[k]) begin
                bad++; $display("FAIL cut_pkt%0d got=%h/%0d/%b want=%h/%0d/%b", k, got_data[k], got_nf[k], got_err[k], exp_data[k], exp_nf[k], exp_err[k]); end
        end
        if (got_nf.size() >= 2) begin
            total++; if (got_err[0] !== 2'b10 || got_nf[0] !== 4) begin bad++; $display("FAIL cut_first got=%b/%0d want=10/4", got_err[0], got_nf[0]); end
            total++; if (got_err[1] !== 2'b11 || got_nf[1] !== 1) begin bad++; $display("FAIL cut_second got=%b/%0d want=11/1", got_err[1], got_nf[1]); end
        end
        flush_logs();
    endtask

    task automatic test_clear_mid();
        bit ok;
        int n;
        i_ready = 1'b1;
        push(mk(1, 1, 0, rnd_pl()));
        push(mk(1, 0, 0, rnd_pl()));
        repeat (4) @(negedge clk);
        #1;
        total++; if (o_num_flits !== CW'(2) || o_valid !== 1'b0) begin bad++; $display("FAIL clr_partial got=%0d/%b want=2/0", o_num_flits, o_valid); end
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk); #1;
        total++; if (o_data !== '0 || o_num_flits !== '0 || o_error !== 2'b00 || o_valid !== 1'b0 || fifo_read_en !== 1'b0) begin
            bad++; $display("FAIL clr_outputs got=%h/%0d/%b/%b/%b want=0/0/00/0/0", o_data, o_num_flits, o_error, o_valid, fifo_read_en); end
        @(negedge clk);
        clear = 1'b0;
        model_err = '0;
        flush_logs();
        push(mk(1, 1, 0, rnd_pl()));
        push(mk(1, 0, 1, rnd_pl()));
        wait_got(1, 30, ok);
        total++; if (!ok) begin bad++; $display("FAIL clr_timeout got=%0d want=1", got_nf.size()); end
        model_build(n);
        for (int k = 0; k < n && k < got_nf.size(); k++) begin
            total++; if (got_data[k] !== exp_data[k] || got_nf[k] !== exp_nf[k] || got_err[k] !== exp_err[k]) begin
                bad++; $display("FAIL clr_pkt%0d got=%h/%0d/%b want=%h/%0d/%b", k, got_data[k], got_nf[k], got_err[k], exp_data[k], exp_nf[k], exp_err[k]); end
        end
        flush_logs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_three_flit();
        test_back_to_back();
        test_gap();
        test_stall();
        test_random();
        test_cut();
        test_clear_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
